div_unit_allocator: RTL and testbench
=====================================

# div_unit_allocator

Allocator and sequencer for the shared divider units behind the complex-integer issue lanes. It grants free divider units to div ops at issue and takes back units whose ops are flushed or cleared. It tracks each unit through reserve, compute and result-hold, and tells the scheduler whether a divider is free so that div ops are only selected when one can be granted. It sits between the complex issue/register-read stages, the recovery manager and the divider datapath.

## Interface
- `LANES`, default 2: number of complex issue lanes that can request a divider.
- `UNITS`, default 2: number of divider units.
- `DIV_LATENCY`, default 34: cycles from `start` to a valid result, ≥ 2.
- `clk` in 1: clock.
- `rst_n` in 1: reset, synchronous and active-low.
- `acq_req` in [LANES]: the lane issues a div op this cycle.
- `acq_grant` out [LANES]: the request is granted this cycle.
- `acq_unit` out [LANES][$clog2(UNITS)]: the unit granted to the lane. Valid only with `acq_grant`.
- `cancel` in [LANES]: the lane's div op was flushed or cleared.
- `cancel_unit` in [LANES][$clog2(UNITS)]: the unit to release.
- `start` in [UNITS]: the register-read stage launches the division on that unit.
- `result_ack` in [UNITS]: writeback consumed the unit's result.
- `flush_all` in 1: recovery flush of all instructions.
- `div_available` out 1: at least one unit is FREE (registered state).
- `div_busy` out [UNITS]: the unit is not FREE.
- `div_done` out [UNITS]: the unit holds a valid result.

## Operation
- Each unit has its own FSM with states FREE, RESERVED, BUSY and DONE.
- FREE → RESERVED on grant.
- RESERVED → BUSY on `start`. The latency counter loads `DIV_LATENCY-1`.
- BUSY decrements the counter each cycle. At 0 it goes to DONE.
- DONE → FREE on `result_ack`.
- `cancel` naming a RESERVED, BUSY or DONE unit sends it to FREE.
- Grants are combinational from the registered state:
  - Lanes are served in index order, lane 0 first.
  - Each granted lane takes a distinct FREE unit, picked by the unit-selection policy (see Configuration).
  - Lanes beyond the number of free units get no grant.
- `flush_all` has top priority. That cycle it forces every unit to FREE and suppresses all grants.
- `cancel` beats `start`, `result_ack` and the counter on the same unit in the same cycle.
- A unit freed in cycle t can be granted from t+1 onward. Same-cycle reuse of a unit is not allowed.
- `start` on a unit that is not RESERVED is ignored.
- `result_ack` on a unit that is not DONE is ignored.
- `cancel` on a FREE unit is ignored.
- Two lanes cancelling the same unit is legal and gives a single release.
- The counter width is $clog2(DIV_LATENCY). It never wraps, because it is only reloaded by `start`.
- Reset values:
  - All units FREE, all counters 0.
  - `div_available`=1, `div_busy`=0, `div_done`=0.
  - `acq_grant`=0 while `rst_n`=0.
  - Rotation pointer 0 (when configured in).

## Timing
- Grant: 0 cycles after `acq_req` (same cycle).
- `div_busy` rises the cycle after the grant.
- `div_done` rises exactly `DIV_LATENCY` cycles after the `start` edge and stays high until `result_ack` or `cancel`.
- `div_available` is registered, so the scheduler sees a one-cycle-stale view. A request that arrives when no unit is free gets no grant. The requester must then replay the op; the block does not queue requests.
- `rst_n` low in the middle of a division takes effect at the next edge and aborts every unit.

## Configuration
- `RSD_DIV_ALLOC_ROUND_ROBIN_EN` defined:
  - Units are searched starting from a rotation pointer.
  - After any grant cycle, the pointer advances to the unit after the last unit granted.
  - This evens out wear and contention across units.
- `RSD_DIV_ALLOC_ROUND_ROBIN_EN` undefined:
  - The lowest-index FREE unit is always granted first.
  - No pointer register exists.

## Structure
- Shared package (the MulDiv types package) holds:
  - `DivUnitState` enum {FREE, RESERVED, BUSY, DONE}.
  - `DivUnitIndexPath` typedef.
  - `DIV_LATENCY` and `DIV_UNIT_NUM` constants.
- One sub-module, `DivUnitSlot`: the per-unit FSM plus latency counter, instantiated `UNITS` times.
- The grant and priority logic stays in the top module.

## Test plan
- Reset, then `acq_req`=2'b01 → `acq_grant`=2'b01 and `acq_unit[0]`=0. Next cycle `div_busy`=2'b01.
- Both lanes request with `UNITS`=2 → both granted, units 0 and 1. Next cycle `div_available`=0. A third request gets `acq_grant`=0.
- `start[0]` at cycle 10 with `DIV_LATENCY`=34 → `div_done[0]`=1 at cycle 44. `result_ack` at 46 → FREE at 47, and a grant is possible at 47.
- `cancel` of unit 1 in BUSY in the same cycle as `start` → unit goes FREE, and `start` is ignored.
- `flush_all` with both units BUSY and `acq_req`=2'b11 → no grant. Next cycle all units FREE.
- With `RSD_DIV_ALLOC_ROUND_ROBIN_EN`, three single grants separated by releases → units 0, 1, 0. Without the macro → units 0, 0, 0.

Source files
------------

// File: rtl/div_unit_allocator_pkg.sv
// Shared types for the divider allocator: per-unit state encoding, unit index
// type and the default divider latency / unit count.
package div_unit_allocator_pkg;

  localparam int DIV_LATENCY      = 34;
  localparam int DIV_UNIT_NUM     = 2;
  localparam int DIV_UNIT_INDEX_W = (DIV_UNIT_NUM > 1) ? $clog2(DIV_UNIT_NUM) : 1;

  typedef logic [DIV_UNIT_INDEX_W-1:0] DivUnitIndexPath;

  typedef enum logic [1:0] {
    FREE     = 2'd0,
    RESERVED = 2'd1,
    BUSY     = 2'd2,
    DONE     = 2'd3
  } DivUnitState;

endpackage

// File: rtl/div_unit_allocator_if.sv
// Issue/recovery/writeback-side bundle of the divider allocator.
//   master : issue lanes, register-read, writeback and recovery (drive requests)
//   slave  : the allocator (drives grants and unit status)
// Signals:
//   acq_req/acq_grant/acq_unit  per-lane acquire handshake, grant is same-cycle
//   cancel/cancel_unit          per-lane release of a unit
//   start/result_ack            per-unit launch and result consumption
//   flush_all                   recovery flush of everything
//   div_available/div_busy/div_done  unit status
interface div_unit_allocator_if
  import div_unit_allocator_pkg::*;
#(
  parameter int LANES = 2,
  parameter int UNITS = DIV_UNIT_NUM,
  parameter int IDX_W = DIV_UNIT_INDEX_W
);

  logic [LANES-1:0]            acq_req;
  logic [LANES-1:0]            acq_grant;
  logic [LANES-1:0][IDX_W-1:0] acq_unit;
  logic [LANES-1:0]            cancel;
  logic [LANES-1:0][IDX_W-1:0] cancel_unit;
  logic [UNITS-1:0]            start;
  logic [UNITS-1:0]            result_ack;
  logic                        flush_all;
  logic                        div_available;
  logic [UNITS-1:0]            div_busy;
  logic [UNITS-1:0]            div_done;

  modport master (
    output acq_req, cancel, cancel_unit, start, result_ack, flush_all,
    input  acq_grant, acq_unit, div_available, div_busy, div_done
  );

  modport slave (
    input  acq_req, cancel, cancel_unit, start, result_ack, flush_all,
    output acq_grant, acq_unit, div_available, div_busy, div_done
  );

endinterface

// File: rtl/div_unit_allocator_slot.sv
// One divider unit's lifecycle: FREE -> RESERVED (grant) -> BUSY (start)
// -> DONE (latency elapsed) -> FREE (result_ack). flush or cancel returns
// any allocated unit to FREE and wins over every other event.
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   flush           global flush, forces FREE
//   grant           allocator hands this unit to a lane
//   cancel_hit      some lane released this unit
//   start           launch the division (only honoured in RESERVED)
//   result_ack      result consumed (only honoured in DONE)
//   free, done      status outputs from the registered state
module div_unit_allocator_slot
  import div_unit_allocator_pkg::*;
#(
  parameter int LATENCY = 34
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
  input  logic grant,
  input  logic cancel_hit,
  input  logic start,
  input  logic result_ack,
  output logic free,
  output logic done
);

  localparam int             CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] LOAD = CNT_W'(LATENCY - 1);

  DivUnitState      state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= FREE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // The counter is loaded with LATENCY-1 on the start edge and DONE is entered
  // on the edge after it reaches zero, so done rises LATENCY edges after start.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (flush) begin
      state_nxt = FREE;
    end else if (cancel_hit && (state != FREE)) begin
      state_nxt = FREE;
    end else begin
      case (state)
        FREE:     if (grant) state_nxt = RESERVED;
        RESERVED: if (start) begin
                    state_nxt = BUSY;
                    cnt_nxt   = LOAD;
                  end
        BUSY:     if (cnt == '0) state_nxt = DONE;
                  else           cnt_nxt   = cnt - 1'b1;
        DONE:     if (result_ack) state_nxt = FREE;
        default:  state_nxt = FREE;
      endcase
    end
  end

  assign free = (state == FREE);
  assign done = (state == DONE);

endmodule

// File: rtl/div_unit_allocator.sv
// Allocator/sequencer for the shared divider units behind the complex issue
// lanes. Grants FREE units to requesting lanes in the same cycle (lane 0
// first, each lane a distinct unit), releases units on cancel/flush, and
// reports unit status to the scheduler.
// Ports:
//   clk    clock
//   rst_n  synchronous active-low reset
//   bus    div_unit_allocator_if.slave (request/grant, cancel, start,
//          result_ack, flush_all, div_available, div_busy, div_done)
// Configuration macro:
//   RSD_DIV_ALLOC_ROUND_ROBIN_EN  defined: the unit search starts at a
//   rotation pointer that moves past the last unit granted.
//   undefined: the lowest-index FREE unit is always granted first.
module div_unit_allocator
  import div_unit_allocator_pkg::*;
#(
  parameter int LANES       = 2,
  parameter int UNITS       = DIV_UNIT_NUM,
  parameter int DIV_LATENCY = div_unit_allocator_pkg::DIV_LATENCY
) (
  input logic                 clk,
  input logic                 rst_n,
  div_unit_allocator_if.slave bus
);

  localparam int IDX_W = (UNITS > 1) ? $clog2(UNITS) : 1;

  logic [UNITS-1:0]            unit_free;
  logic [UNITS-1:0]            unit_done;
  logic [UNITS-1:0]            unit_grant;
  logic [UNITS-1:0]            unit_cancel;
  logic [LANES-1:0]            grant;
  logic [LANES-1:0][IDX_W-1:0] grant_unit;
  logic [IDX_W-1:0]            search_base;
  logic                        grant_ok;

`ifdef RSD_DIV_ALLOC_ROUND_ROBIN_EN
  logic [IDX_W-1:0] rr_ptr, rr_ptr_nxt;

  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] u);
    if (int'(u) >= UNITS - 1) return '0;
    return u + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) rr_ptr <= '0;
    else        rr_ptr <= rr_ptr_nxt;
  end

  // Lanes take units in search order, so the highest granted lane holds the
  // last unit handed out this cycle.
  always_comb begin
    rr_ptr_nxt = rr_ptr;
    for (int l = 0; l < LANES; l++) begin
      if (grant[l]) rr_ptr_nxt = wrap_inc(grant_unit[l]);
    end
  end

  assign search_base = rr_ptr;
`else
  assign search_base = '0;
`endif

  // Grants look only at the registered unit state, so a unit released this
  // cycle cannot be handed out again until the next one.
  assign grant_ok = rst_n && !bus.flush_all;

  always_comb begin : grant_search
    logic [UNITS-1:0] taken;
    logic             found;
    int               sum;
    logic [IDX_W-1:0] idx;
    taken      = '0;
    found      = 1'b0;
    sum        = 0;
    idx        = '0;
    grant      = '0;
    grant_unit = '0;
    for (int l = 0; l < LANES; l++) begin
      found = 1'b0;
      if (bus.acq_req[l] && grant_ok) begin
        for (int k = 0; k < UNITS; k++) begin
          sum = int'(search_base) + k;
          if (sum >= UNITS) sum = sum - UNITS;
          idx = IDX_W'(sum);
          if (!found && unit_free[idx] && !taken[idx]) begin
            found         = 1'b1;
            taken[idx]    = 1'b1;
            grant[l]      = 1'b1;
            grant_unit[l] = idx;
          end
        end
      end
    end
  end

  // Several lanes naming the same unit collapse into a single release.
  always_comb begin
    unit_grant  = '0;
    unit_cancel = '0;
    for (int l = 0; l < LANES; l++) begin
      if (grant[l])      unit_grant[grant_unit[l]]       = 1'b1;
      if (bus.cancel[l]) unit_cancel[bus.cancel_unit[l]] = 1'b1;
    end
  end

  for (genvar u = 0; u < UNITS; u++) begin : g_unit
    div_unit_allocator_slot #(
      .LATENCY    (DIV_LATENCY)
    ) u_slot (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush      (bus.flush_all),
      .grant      (unit_grant[u]),
      .cancel_hit (unit_cancel[u]),
      .start      (bus.start[u]),
      .result_ack (bus.result_ack[u]),
      .free       (unit_free[u]),
      .done       (unit_done[u])
    );
  end

  assign bus.acq_grant     = grant;
  assign bus.acq_unit      = grant_unit;
  assign bus.div_available = |unit_free;
  assign bus.div_busy      = ~unit_free;
  assign bus.div_done      = unit_done;

endmodule

// File: tb/tb_div_unit_allocator.sv
module tb_div_unit_allocator;

  localparam int LANES = 2;
  localparam int UNITS = 2;
  localparam int LAT   = 34;
  localparam int IDX_W = 1;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  div_unit_allocator_if #(.LANES(LANES), .UNITS(UNITS), .IDX_W(IDX_W)) bus ();

  div_unit_allocator #(
    .LANES       (LANES),
    .UNITS       (UNITS),
    .DIV_LATENCY (LAT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a unit is either unallocated, allocated-and-waiting, or
  // launched with a timestamp of the edge at which its result becomes valid.
  bit m_alloc    [UNITS];
  bit m_launched [UNITS];
  int m_done_at  [UNITS];
  int m_edges  = 0;
  int m_ptr    = 0;
  bit model_on = 1'b0;

  function automatic bit m_is_done(input int u);
    return m_alloc[u] && m_launched[u] && (m_edges >= m_done_at[u]);
  endfunction

  function automatic void model_grants(output logic [LANES-1:0] g,
                                       output logic [LANES-1:0][IDX_W-1:0] gu);
    int order[$];
    int n;
    int idx;
    g  = '0;
    gu = '0;
    n  = 0;
    for (int k = 0; k < UNITS; k++) begin
      idx = (m_ptr + k) % UNITS;
      if (!m_alloc[idx]) order.push_back(idx);
    end
    if (rst_n === 1'b1 && bus.flush_all !== 1'b1) begin
      for (int l = 0; l < LANES; l++) begin
        if (bus.acq_req[l] && n < order.size()) begin
          g[l]  = 1'b1;
          gu[l] = IDX_W'(order[n]);
          n++;
        end
      end
    end
  endfunction

  function automatic void model_step(input logic [LANES-1:0] g,
                                     input logic [LANES-1:0][IDX_W-1:0] gu);
    bit prev_done [UNITS];
    bit hit;
    if (rst_n !== 1'b1 || bus.flush_all === 1'b1) begin
      for (int u = 0; u < UNITS; u++) begin
        m_alloc[u]    = 1'b0;
        m_launched[u] = 1'b0;
      end
      if (rst_n !== 1'b1) begin
        m_ptr    = 0;
        model_on = 1'b1;
      end
    end else begin
      for (int u = 0; u < UNITS; u++) prev_done[u] = m_is_done(u);
      for (int u = 0; u < UNITS; u++) begin
        if (m_alloc[u]) begin
          hit = 1'b0;
          for (int l = 0; l < LANES; l++)
            if (bus.cancel[l] && int'(bus.cancel_unit[l]) == u) hit = 1'b1;
          if (hit) begin
            m_alloc[u]    = 1'b0;
            m_launched[u] = 1'b0;
          end else if (!m_launched[u] && bus.start[u]) begin
            m_launched[u] = 1'b1;
            m_done_at[u]  = m_edges + 1 + LAT;
          end else if (prev_done[u] && bus.result_ack[u]) begin
            m_alloc[u]    = 1'b0;
            m_launched[u] = 1'b0;
          end
        end
      end
      for (int l = 0; l < LANES; l++) begin
        if (g[l]) begin
          m_alloc[gu[l]]    = 1'b1;
          m_launched[gu[l]] = 1'b0;
`ifdef RSD_DIV_ALLOC_ROUND_ROBIN_EN
          m_ptr = (int'(gu[l]) + 1) % UNITS;
`endif
        end
      end
    end
    m_edges++;
  endfunction

  // Compare every cycle at the falling edge, then advance the model by the
  // inputs that the next rising edge will sample.
  always @(negedge clk) begin
    logic [LANES-1:0]            eg;
    logic [LANES-1:0][IDX_W-1:0] eu;
    logic [UNITS-1:0]            eb;
    logic [UNITS-1:0]            ed;
    model_grants(eg, eu);
    if (model_on) begin
      for (int u = 0; u < UNITS; u++) begin
        eb[u] = m_alloc[u];
        ed[u] = m_is_done(u);
      end
      check("model acq_grant", 32'(bus.acq_grant), 32'(eg));
      for (int l = 0; l < LANES; l++)
        if (eg[l]) check("model acq_unit", 32'(bus.acq_unit[l]), 32'(eu[l]));
      check("model div_busy", 32'(bus.div_busy), 32'(eb));
      check("model div_done", 32'(bus.div_done), 32'(ed));
      check("model div_available", 32'(bus.div_available), 32'(~&eb));
    end
    model_step(eg, eu);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    bus.acq_req     = '0;
    bus.cancel      = '0;
    bus.cancel_unit = '0;
    bus.start       = '0;
    bus.result_ack  = '0;
    bus.flush_all   = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    logic [IDX_W-1:0] got;
    int               exp_rr [3];
`ifdef RSD_DIV_ALLOC_ROUND_ROBIN_EN
    exp_rr = '{0, 1, 0};
`else
    exp_rr = '{0, 0, 0};
`endif

    // Reset: requests while rst_n is low are never granted.
    rst_n = 1'b0;
    clear_inputs();
    bus.acq_req = 2'b11;
    step();
    step();
    at_neg();
    check("reset acq_grant", 32'(bus.acq_grant), 32'h0);
    check("reset div_busy", 32'(bus.div_busy), 32'h0);
    check("reset div_done", 32'(bus.div_done), 32'h0);
    check("reset div_available", 32'(bus.div_available), 32'h1);
    step();
    bus.acq_req = '0;
    rst_n = 1'b1;
    step();

    // Single request from lane 0.
    bus.acq_req = 2'b01;
    at_neg();
    check("single grant", 32'(bus.acq_grant), 32'h1);
    check("single unit", 32'(bus.acq_unit[0]), 32'h0);
    step();
    bus.acq_req = '0;
    at_neg();
    check("single busy", 32'(bus.div_busy), 32'h1);

    // Both lanes, then a third request with no unit free.
    do_reset();
    bus.acq_req = 2'b11;
    at_neg();
    check("dual grant", 32'(bus.acq_grant), 32'h3);
    check("dual unit0", 32'(bus.acq_unit[0]), 32'h0);
    check("dual unit1", 32'(bus.acq_unit[1]), 32'h1);
    step();
    bus.acq_req = 2'b01;
    at_neg();
    check("full available", 32'(bus.div_available), 32'h0);
    check("full grant", 32'(bus.acq_grant), 32'h0);
    check("full busy", 32'(bus.div_busy), 32'h3);
    step();
    bus.acq_req = '0;

    // Latency: done rises exactly LAT edges after the start edge.
    bus.start = 2'b01;
    step();
    bus.start = '0;
    repeat (LAT - 1) step();
    at_neg();
    check("latency early done", 32'(bus.div_done), 32'h0);
    step();
    at_neg();
    check("latency done", 32'(bus.div_done), 32'h1);
    bus.start = 2'b01;
    step();
    bus.start = '0;
    at_neg();
    check("done hold", 32'(bus.div_done), 32'h1);
    check("done hold busy", 32'(bus.div_busy), 32'h3);
    step();
    bus.result_ack = 2'b11;
    step();
    bus.result_ack = '0;
    bus.acq_req    = 2'b01;
    at_neg();
    check("ack busy", 32'(bus.div_busy), 32'h2);
    check("ack done", 32'(bus.div_done), 32'h0);
    check("regrant", 32'(bus.acq_grant), 32'h1);
    check("regrant unit", 32'(bus.acq_unit[0]), 32'h0);
    step();
    bus.acq_req = '0;

    // Cancel beats start; duplicate cancels give a single release.
    bus.start = 2'b10;
    step();
    bus.start          = 2'b10;
    bus.cancel         = 2'b10;
    bus.cancel_unit[1] = 1'b1;
    step();
    bus.start  = '0;
    bus.cancel = '0;
    at_neg();
    check("cancel busy", 32'(bus.div_busy), 32'h1);
    check("cancel done", 32'(bus.div_done), 32'h0);
    step();
    bus.cancel      = 2'b11;
    bus.cancel_unit = '0;
    step();
    bus.cancel = '0;
    at_neg();
    check("dup cancel busy", 32'(bus.div_busy), 32'h0);
    check("dup cancel available", 32'(bus.div_available), 32'h1);
    step();

    // Flush with both units busy suppresses grants and frees everything.
    bus.acq_req = 2'b11;
    step();
    bus.acq_req = '0;
    bus.start   = 2'b11;
    step();
    bus.start = '0;
    step();
    at_neg();
    check("pre-flush busy", 32'(bus.div_busy), 32'h3);
    step();
    bus.flush_all = 1'b1;
    bus.acq_req   = 2'b11;
    at_neg();
    check("flush grant", 32'(bus.acq_grant), 32'h0);
    step();
    bus.flush_all = 1'b0;
    bus.acq_req   = '0;
    at_neg();
    check("flush busy", 32'(bus.div_busy), 32'h0);
    check("flush done", 32'(bus.div_done), 32'h0);
    check("flush available", 32'(bus.div_available), 32'h1);
    step();

    // Unit selection across three single grants separated by releases.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      bus.acq_req = 2'b01;
      at_neg();
      check("select grant", 32'(bus.acq_grant), 32'h1);
      check("select unit", 32'(bus.acq_unit[0]), 32'(exp_rr[i]));
      got = bus.acq_unit[0];
      step();
      bus.acq_req        = '0;
      bus.cancel         = 2'b01;
      bus.cancel_unit[0] = got;
      step();
      bus.cancel = '0;
    end

    // Reset in the middle of a division aborts it.
    bus.acq_req = 2'b01;
    step();
    bus.acq_req = '0;
    bus.start   = 2'b01;
    step();
    bus.start = '0;
    repeat (5) step();
    at_neg();
    check("mid-div busy", 32'(bus.div_busy), 32'h1);
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    at_neg();
    check("abort busy", 32'(bus.div_busy), 32'h0);
    check("abort done", 32'(bus.div_done), 32'h0);
    step();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
